ga_req_issue: RTL and testbench

GA_REQ_ISSUE -- requirements
Module: ga_req_issue

---
 rtl/ga_pkg.sv | 39 +++
 rtl/ga_req_fifo.sv | 51 +++++
 rtl/ga_req_issue.sv | 172 +++++++++++++++++
 tb/tb_ga_req_issue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared types for the GA request/response path between the core and ga_coprocessor.
package ga_pkg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_addr;
    logic        we;
  } ga_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        error;
    logic        busy;
    logic        overflow;
    logic        underflow;
  } ga_resp_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        we;
    logic        error;
    logic        overflow;
    logic        underflow;
    logic        timeout;
  } ga_issue_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } ga_issue_state_e;

endpackage

// File: rtl/ga_req_fifo.sv
// Request FIFO with wrap-bit pointers; storage is intentionally not reset.
module ga_req_fifo
  import ga_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  ga_req_t                  i_data,
  input  logic                     i_pop,
  output ga_req_t                  o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0] r_wptr;
  logic [AddrW:0] r_rptr;
  ga_req_t        r_mem [Depth];
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_count = r_wptr - r_rptr;
  assign o_head  = r_mem[r_rptr[AddrW-1:0]];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AddrW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ga_req_issue.sv
// Queues core GA requests and issues them one at a time to the coprocessor, with a
// response timeout, stray-response detection and a flush that discards everything.
module ga_req_issue
  import ga_pkg::*;
#(
  parameter int unsigned Depth         = 4,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_req_valid_i,
  output logic                   core_req_ready_o,
  input  ga_req_t                core_req_i,
  output ga_req_t                ga_req_o,
  input  ga_resp_t               ga_resp_i,
  output logic                   core_resp_valid_o,
  input  logic                   core_resp_ready_i,
  output ga_issue_resp_t         core_resp_o,
  input  logic                   flush_i,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic                   stray_resp_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  ga_issue_state_e r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [31:0]     r_result, w_result_next;
  logic            r_error, w_error_next;
  logic            r_ovf, w_ovf_next;
  logic            r_unf, w_unf_next;
  logic            r_timeout, w_timeout_next;
  logic            r_stray;

  ga_req_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_pop;
  logic    w_issue;
  logic    w_unused_valid;

  // The payload valid bits carry no meaning here; ga_req_o.valid is the issue pulse.
  assign w_unused_valid = core_req_i.valid ^ w_head.valid;

  assign core_req_ready_o = !w_full && !flush_i;

  ga_req_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (flush_i),
    .i_push  (core_req_valid_i && core_req_ready_o),
    .i_data  (core_req_i),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy_o)
  );

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_result_next  = r_result;
    w_error_next   = r_error;
    w_ovf_next     = r_ovf;
    w_unf_next     = r_unf;
    w_timeout_next = r_timeout;
    w_pop          = 1'b0;
    w_issue        = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (!w_empty) w_state_next = StIssue;
      end
      StIssue: begin
        if (!ga_resp_i.busy) begin
          w_issue      = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StWait;
        end
      end
      StWait: begin
        // A response on the final count cycle takes priority over the timeout.
        if (ga_resp_i.valid) begin
          w_result_next  = ga_resp_i.result;
          w_error_next   = ga_resp_i.error;
          w_ovf_next     = ga_resp_i.overflow;
          w_unf_next     = ga_resp_i.underflow;
          w_timeout_next = 1'b0;
          w_state_next   = StResp;
        end else if (r_cnt == CntLast) begin
          w_result_next  = '0;
          w_error_next   = 1'b1;
          w_ovf_next     = 1'b0;
          w_unf_next     = 1'b0;
          w_timeout_next = 1'b1;
          w_state_next   = StResp;
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      StResp: begin
        if (core_resp_ready_i) begin
          w_pop        = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (flush_i) begin
      w_state_next   = StIdle;
      w_cnt_next     = '0;
      w_pop          = 1'b0;
      w_result_next  = '0;
      w_error_next   = 1'b0;
      w_ovf_next     = 1'b0;
      w_unf_next     = 1'b0;
      w_timeout_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_result  <= '0;
      r_error   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_timeout <= 1'b0;
      r_stray   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_result  <= w_result_next;
      r_error   <= w_error_next;
      r_ovf     <= w_ovf_next;
      r_unf     <= w_unf_next;
      r_timeout <= w_timeout_next;
      r_stray   <= ga_resp_i.valid && (r_state != StWait);
    end
  end

  assign stray_resp_o      = r_stray;
  assign core_resp_valid_o = (r_state == StResp);

  always_comb begin
    ga_req_o = '0;
    if (r_state == StIssue || r_state == StWait) begin
      ga_req_o       = w_head;
      ga_req_o.valid = w_issue;
    end
  end

  always_comb begin
    core_resp_o = '0;
    if (r_state == StResp) begin
      core_resp_o.result    = r_result;
      core_resp_o.rd_addr   = w_head.rd_addr;
      core_resp_o.we        = w_head.we;
      core_resp_o.error     = r_error;
      core_resp_o.overflow  = r_ovf;
      core_resp_o.underflow = r_unf;
      core_resp_o.timeout   = r_timeout;
    end
  end

endmodule

// File: tb/tb_ga_req_issue.sv
// Directed bench for ga_req_issue with a response scoreboard queue.
module tb_ga_req_issue;
  import ga_pkg::*;

  localparam int unsigned Depth         = 4;
  localparam int unsigned TimeoutCycles = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   core_req_valid;
  logic                   core_req_ready;
  ga_req_t                core_req;
  ga_req_t                ga_req;
  ga_resp_t               ga_resp;
  logic                   core_resp_valid;
  logic                   core_resp_ready;
  ga_issue_resp_t         core_resp;
  logic                   flush;
  logic [$clog2(Depth):0] occupancy;
  logic                   stray;

  int n_vec  = 0;
  int n_fail = 0;
  ga_issue_resp_t exp_q[$];
  ga_req_t        reqs [8];

  ga_req_issue #(
    .Depth         (Depth),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .core_req_valid_i  (core_req_valid),
    .core_req_ready_o  (core_req_ready),
    .core_req_i        (core_req),
    .ga_req_o          (ga_req),
    .ga_resp_i         (ga_resp),
    .core_resp_valid_o (core_resp_valid),
    .core_resp_ready_i (core_resp_ready),
    .core_resp_o       (core_resp),
    .flush_i           (flush),
    .occupancy_o       (occupancy),
    .stray_resp_o      (stray)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic ga_req_t mk_req(input int i);
    ga_req_t r;
    r.valid   = 1'b1;
    r.op      = 4'(i + 1);
    r.src_a   = 32'h1000 + 32'(i);
    r.src_b   = 32'h2000 + 32'(i * 3);
    r.rd_addr = 5'(i + 3);
    r.we      = (i % 2) == 0;
    return r;
  endfunction

  function automatic ga_req_t issued(input int i, input logic v);
    ga_req_t r;
    r       = reqs[i];
    r.valid = v;
    return r;
  endfunction

  function automatic ga_issue_resp_t mk_resp(input ga_req_t q, input logic [31:0] res,
                                             input logic err, input logic ov,
                                             input logic un, input logic to);
    ga_issue_resp_t e;
    e.result    = res;
    e.rd_addr   = q.rd_addr;
    e.we        = q.we;
    e.error     = err;
    e.overflow  = ov;
    e.underflow = un;
    e.timeout   = to;
    return e;
  endfunction

  task automatic check_resp(input string tag);
    ga_issue_resp_t e;
    check({tag, "_pending"}, 128'(exp_q.size() > 0), 128'(1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check(tag, 128'(core_resp), 128'(e));
  endtask

  // Called at +1 of a cycle; returns at +1 of the first WAIT cycle.
  task automatic run_to_wait(input int idx, input string tag);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ga_req.valid) break;
      @(posedge clk);
      #1;
    end
    check(tag, 128'(ga_req), 128'(issued(idx, 1'b1)));
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    core_req_valid  = 1'b0;
    core_req        = '0;
    ga_resp         = '0;
    core_resp_ready = 1'b0;
    flush           = 1'b0;
    for (int i = 0; i < 8; i++) reqs[i] = mk_req(i);

    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rst_ga_req", 128'(ga_req), '0);
    check("rst_resp_valid", 128'(core_resp_valid), '0);
    check("rst_core_resp", 128'(core_resp), '0);
    check("rst_occupancy", 128'(occupancy), '0);
    check("rst_stray", 128'(stray), '0);
    check("rst_ready", 128'(core_req_ready), 128'(1));

    // Single request: issue at +2, response at +4, core result at +5.
    tick(); core_req_valid = 1'b1; core_req = reqs[0]; settle();
    check("t1_ready", 128'(core_req_ready), 128'(1));
    tick(); core_req_valid = 1'b0; settle();
    check("t1_occ", 128'(occupancy), 128'(1));
    check("t1_c1_issue", 128'(ga_req.valid), '0);
    tick(); settle();
    check("t1_issue", 128'(ga_req), 128'(issued(0, 1'b1)));
    tick(); settle();
    check("t1_wait_head", 128'(ga_req), 128'(issued(0, 1'b0)));
    tick();
    ga_resp.valid  = 1'b1;
    ga_resp.result = 32'h5;
    exp_q.push_back(mk_resp(reqs[0], 32'h5, 1'b0, 1'b0, 1'b0, 1'b0));
    settle();
    check("t1_c4_rv", 128'(core_resp_valid), '0);
    tick(); ga_resp = '0; core_resp_ready = 1'b1; settle();
    check("t1_c5_rv", 128'(core_resp_valid), 128'(1));
    check_resp("t1_resp");
    tick(); core_resp_ready = 1'b0; settle();
    check("t1_done_rv", 128'(core_resp_valid), '0);
    check("t1_done_occ", 128'(occupancy), '0);
    check("t1_stray", 128'(stray), '0);

    // Fill to Depth; fifth push held off until the first pop.
    for (int i = 0; i < 4; i++) begin
      tick(); core_req_valid = 1'b1; core_req = reqs[i + 1]; settle();
      check("t2_ready_open", 128'(core_req_ready), 128'(1));
    end
    tick();
    core_req       = reqs[5];
    ga_resp.valid  = 1'b1;
    ga_resp.result = 32'h10;
    exp_q.push_back(mk_resp(reqs[1], 32'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    settle();
    check("t2_full_ready", 128'(core_req_ready), '0);
    check("t2_full_occ", 128'(occupancy), 128'(4));
    tick(); ga_resp = '0; core_resp_ready = 1'b1; settle();
    check("t2_rv", 128'(core_resp_valid), 128'(1));
    check_resp("t2_resp");
    check("t2_pop_cycle_ready", 128'(core_req_ready), '0);
    tick(); core_resp_ready = 1'b0; ga_resp.busy = 1'b1; settle();
    check("t2_after_pop_ready", 128'(core_req_ready), 128'(1));
    check("t2_after_pop_occ", 128'(occupancy), 128'(3));

    // Busy held for 7 ISSUE cycles, then exactly one pulse.
    tick(); core_req_valid = 1'b0; settle();
    check("t2_fifth_in", 128'(occupancy), 128'(4));
    check("t3_busy_valid", 128'(ga_req.valid), '0);
    for (int i = 0; i < 6; i++) begin
      tick(); settle();
      check("t3_busy_valid", 128'(ga_req.valid), '0);
    end
    tick(); ga_resp.busy = 1'b0; settle();
    check("t3_issue", 128'(ga_req), 128'(issued(2, 1'b1)));

    // Timeout after 16 WAIT cycles with no response.
    exp_q.push_back(mk_resp(reqs[2], 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 16; i++) begin
      tick(); settle();
      check("t4_wait_rv", 128'(core_resp_valid), '0);
      check("t4_wait_hold", 128'(ga_req), 128'(issued(2, 1'b0)));
    end
    tick(); core_resp_ready = 1'b1; settle();
    check("t4_to_rv", 128'(core_resp_valid), 128'(1));
    check_resp("t4_timeout_resp");

    // Response on the 16th WAIT cycle beats the timeout.
    tick(); core_resp_ready = 1'b0;
    run_to_wait(3, "t5_issue");
    for (int i = 0; i < 15; i++) begin
      settle();
      check("t5_wait_rv", 128'(core_resp_valid), '0);
      tick();
    end
    ga_resp.valid    = 1'b1;
    ga_resp.result   = 32'hAB;
    ga_resp.overflow = 1'b1;
    exp_q.push_back(mk_resp(reqs[3], 32'hAB, 1'b0, 1'b1, 1'b0, 1'b0));
    settle();
    check("t5_last_rv", 128'(core_resp_valid), '0);
    tick(); ga_resp = '0; core_resp_ready = 1'b1; settle();
    check("t5_rv", 128'(core_resp_valid), 128'(1));
    check_resp("t5_late_resp");

    // Flush in WAIT with 3 entries, late response becomes stray.
    tick(); core_resp_ready = 1'b0; core_req_valid = 1'b1; core_req = reqs[6]; settle();
    check("t6_push_ready", 128'(core_req_ready), 128'(1));
    tick(); core_req_valid = 1'b0;
    run_to_wait(4, "t6_issue");
    settle();
    check("t6_occ3", 128'(occupancy), 128'(3));
    tick(); flush = 1'b1; settle();
    check("t6_flush_ready", 128'(core_req_ready), '0);
    tick(); flush = 1'b0; settle();
    check("t6_flush_occ", 128'(occupancy), '0);
    check("t6_flush_idle", 128'(ga_req), '0);
    check("t6_flush_ready_back", 128'(core_req_ready), 128'(1));
    tick(); ga_resp.valid = 1'b1; ga_resp.result = 32'h99; settle();
    check("t6_stray_early", 128'(stray), '0);
    tick(); ga_resp = '0; settle();
    check("t6_stray", 128'(stray), 128'(1));
    check("t6_no_rv", 128'(core_resp_valid), '0);
    tick(); settle();
    check("t6_stray_clear", 128'(stray), '0);
    check("t6_no_rv2", 128'(core_resp_valid), '0);
    check("t6_idle", 128'(ga_req), '0);

    // RESP held for 10 cycles; stray in RESP must not disturb the result.
    tick(); core_req_valid = 1'b1; core_req = reqs[7]; settle();
    tick(); core_req_valid = 1'b0;
    run_to_wait(7, "t7_issue");
    ga_resp.valid     = 1'b1;
    ga_resp.result    = 32'h77;
    ga_resp.error     = 1'b1;
    ga_resp.underflow = 1'b1;
    exp_q.push_back(mk_resp(reqs[7], 32'h77, 1'b1, 1'b0, 1'b1, 1'b0));
    tick(); ga_resp = '0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t7_hold_rv", 128'(core_resp_valid), 128'(1));
      check("t7_hold_resp", 128'(core_resp), 128'(exp_q[0]));
      check("t7_hold_occ", 128'(occupancy), 128'(1));
      check("t7_hold_stray", 128'(stray), 128'(i == 4));
      if (i == 3) begin
        ga_resp.valid  = 1'b1;
        ga_resp.result = 32'hDEAD;
      end else begin
        ga_resp = '0;
      end
      tick();
    end
    ga_resp = '0; core_resp_ready = 1'b1; settle();
    check("t7_rv", 128'(core_resp_valid), 128'(1));
    check_resp("t7_resp");
    tick(); core_resp_ready = 1'b0; settle();
    check("t7_popped_occ", 128'(occupancy), '0);
    check("t7_popped_rv", 128'(core_resp_valid), '0);

    // Reset in RESP abandons the request.
    tick(); core_req_valid = 1'b1; core_req = reqs[0]; settle();
    tick(); core_req_valid = 1'b0;
    run_to_wait(0, "t8_issue");
    ga_resp.valid  = 1'b1;
    ga_resp.result = 32'h1;
    tick(); ga_resp = '0; settle();
    check("t8_rv", 128'(core_resp_valid), 128'(1));
    rst = 1'b1;
    tick(); rst = 1'b0; settle();
    check("t8_rst_rv", 128'(core_resp_valid), '0);
    check("t8_rst_occ", 128'(occupancy), '0);
    check("t8_rst_req", 128'(ga_req), '0);
    tick(); tick(); settle();
    check("t8_stays_idle", 128'(ga_req.valid), '0);
    check("t8_no_rv", 128'(core_resp_valid), '0);
    check("sb_empty", 128'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
